// File: rtl/latch_access_sched.sv
// rtl/latch_access_sched.sv - round-robin sequencer sharing one level-sensitive latch stage among NREQ requesters
module latch_access_sched #(
    parameter int NREQ        = 4,
    parameter int OPEN_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op_a,
    input  logic [NREQ-1:0] op_b,
    input  logic [NREQ-1:0] op_flip,
    output logic [NREQ-1:0] gnt,
    output logic            lat_en,
    output logic            lat_a,
    output logic            lat_b,
    output logic            lat_flip,
    input  logic            lat_y,
    output logic            done,
    output logic            result,
    output logic            busy
);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAXC = (OPEN_CYCLES > HOLD_CYCLES) ? OPEN_CYCLES : HOLD_CYCLES;
    localparam int CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_OPEN  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic            open_last;
    logic            hold_last;

    // Rotating priority search: first set req at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    assign open_last = (cnt == CW'(OPEN_CYCLES - 1));
    assign hold_last = (cnt == CW'(HOLD_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_OPEN;
            S_OPEN:  if (open_last) state_nxt = S_HOLD;
            S_HOLD:  if (hold_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // lat_en, done and busy are flops decoded from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            gnt      <= '0;
            lat_en   <= 1'b0;
            lat_a    <= 1'b0;
            lat_b    <= 1'b0;
            lat_flip <= 1'b0;
            done     <= 1'b0;
            result   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state  <= state_nxt;
            lat_en <= (state_nxt == S_OPEN);
            done   <= (state_nxt == S_DONE);
            busy   <= (state_nxt != S_IDLE);
            if (state_nxt != state || (state != S_OPEN && state != S_HOLD)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == S_IDLE && win_found) begin
                gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                owner    <= win_idx;
                lat_a    <= op_a[win_idx];
                lat_b    <= op_b[win_idx];
                lat_flip <= op_flip[win_idx];
            end
            if (state == S_HOLD && hold_last) begin
                result <= lat_y;
            end
            if (state == S_DONE) begin
                gnt    <= '0;
                rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
            end
        end
    end
endmodule
